multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control sequencer for the RV32 core: accepts one 32-bit instruction at a time over a valid/ready handshake and decodes opcode, func3 and func7. It then steps through DECODE/EXEC/MEM/WB states, driving the datapath strobes (branch, memRead, memWrite, memToReg, aluSrc, regWrite, aluOp, pcWrite) one phase at a time. It replaces the single-cycle opcode decoder, adds a memory handshake with timeout, and adds illegal-instruction trapping.

## Interface
- `ALU_OP_W`, 3, width of `aluOp`; minimum 3.
- `MEM_TIMEOUT`, 15, maximum cycles spent in MEM waiting for `memReady` before trapping; range 1..255.
- `clk`  input  1  core clock; all state changes on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `instrValid`  input  1  `instruction` is valid.
- `instrReady`  output  1  block can accept an instruction.
- `instruction`  input  32  raw instruction word; opcode [6:0], func3 [14:12], func7 [31:25].
- `memReady`  input  1  data memory has completed the current read or write.
- `trapAck`  input  1  trap handler acknowledges `illegal`.
- `branch`, `memRead`, `memWrite`, `memToReg`, `aluSrc`, `regWrite`, `pcWrite`  output  1 each  datapath strobes.
- `aluOp`  output  ALU_OP_W  ALU class; upper bits beyond 3 are zero.
- `illegal`  output  1  trap active.
- `trapCause`  output  2  01 illegal opcode, 10 illegal func7, 11 memory timeout, 00 none.
- `state`  output  3  current state, for debug.

## Operation
- **State encoding:** IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 return to IDLE on the next edge.
- **IDLE**
  - `instrReady`=1.
  - On `instrValid && instrReady`, the full 32-bit instruction is latched into the internal IR; next state is DECODE.
- **DECODE**
  - Legal opcodes: LOAD 0000011, STORE 0100011, BRANCH 1100011, OP 0110011, OP-IMM 0010011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode, including AMO 0101111, goes to TRAP with cause 01.
  - OP with func7 not in {0000000, 0100000} goes to TRAP with cause 10; see Configuration for the extension case.
  - Otherwise next state is EXEC.
- **aluOp** is driven in DECODE, EXEC and MEM:
  - LOAD/STORE → 000
  - BRANCH → 001
  - OP → 010
  - JAL/JALR/LUI/AUIPC → 011
  - OP-IMM → 110
  - `aluOp` is 111 in every other state.
- **aluSrc**=1 in DECODE, EXEC and MEM for OP-IMM, LOAD, STORE, JAL, JALR, LUI, AUIPC; 0 for OP and BRANCH.
- **EXEC** (one cycle)
  - BRANCH: `branch`=1 and `pcWrite`=1, next state IDLE.
  - LOAD/STORE: next state MEM.
  - All others: next state WB.
- **MEM**
  - `memRead`=1 for LOAD, `memWrite`=1 for STORE; held every cycle until `memReady`.
  - On `memReady`: LOAD goes to WB; STORE asserts `pcWrite`=1 in that cycle and goes to IDLE.
  - A wait counter is cleared on MEM entry and increments each cycle without `memReady`.
  - When the counter reaches `MEM_TIMEOUT` with `memReady` low, next state is TRAP with cause 11.
  - `memReady` asserted in the same cycle the counter reaches `MEM_TIMEOUT` counts as completion; completion wins.
- **WB** (one cycle)
  - `regWrite`=1 and `pcWrite`=1.
  - `memToReg`=1 for LOAD only.
  - STORE and BRANCH never reach WB, so they never assert `regWrite`.
  - Next state IDLE.
- **TRAP**
  - `illegal`=1 and `trapCause` held; all datapath strobes are 0.
  - On `trapAck`, `trapCause` clears and the next state is IDLE.
  - `trapAck` outside TRAP is ignored.
- **Strobe gating:** outside the states listed above, every strobe is 0.
- **Output decode:** all outputs are decoded from registered state and IR only. `instrValid`, `memReady` and `trapAck` affect outputs only after the next edge, with one exception: `pcWrite` on STORE completion depends combinationally on `memReady`.

## Timing
- **Reset:** while `rst_n`=0 at a rising edge → state IDLE, IR=0, wait counter 0, `trapCause` 00.
  - All outputs are 0, except `aluOp`=111, `state`=0 and `instrReady`=1.
  - Reset mid-instruction, including in MEM or TRAP, aborts with no further strobes.
- **Latency:** handshake accept edge → DECODE next cycle.
- **Instruction-class cycle counts, accept edge to `instrReady` again:**
  - OP, OP-IMM, JAL, JALR, LUI, AUIPC: 4 cycles.
  - BRANCH: 3 cycles.
  - LOAD: 4 + memory wait cycles (memory wait ≥1).
  - STORE: 3 + memory wait cycles.
- **Back-to-back issue:** `instrValid` held high is accepted once per return to IDLE; no instruction is accepted outside IDLE.

## Configuration
- `CONTROL_M_EXT_EN` defined: OP with func7=0000001 is legal, with `aluOp`=101 and the same state sequence as other OP instructions.
- Not defined: func7=0000001 traps with cause 10, and `aluOp` value 101 is never produced.

## Test plan
- **OP-IMM:** reset, then issue OP-IMM 0x00500093 → `state` 0→1→2→4→0; `aluOp`=110 and `aluSrc`=1 in DECODE/EXEC; `regWrite`=`pcWrite`=1 only in WB; `instrReady` high again 4 cycles after accept.
- **LOAD with wait:** issue LOAD 0x00002103 with `memReady` held low 3 cycles → `memRead`=1 for 4 cycles, then WB with `memToReg`=1 and `regWrite`=1.
- **STORE and BRANCH:** issue STORE 0x00112023 → `memWrite` until `memReady`, `pcWrite` in the completion cycle, `regWrite` never 1. Issue BRANCH 0x00208463 → `branch`=`pcWrite`=1 for exactly 1 cycle in EXEC, `aluOp`=001.
- **Illegal and func7 traps:** issue opcode 0101111 → TRAP with cause 01 and `illegal`=1 until `trapAck`, then IDLE. Issue OP with func7=0000001 → cause 10 without the macro; with `CONTROL_M_EXT_EN` it completes with `aluOp`=101.
- **Memory timeout:** `MEM_TIMEOUT`=4, LOAD with `memReady` never asserted → TRAP with cause 11 after exactly 4 MEM cycles. Repeat with `memReady` in the 4th cycle → completes to WB, no trap.
- **Reset mid-operation:** pull `rst_n` low for 1 edge while in MEM → next cycle `state`=0, `memRead`=0, `trapCause`=00, `instrReady`=1.

Source files
------------

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Instruction handshake, memory handshake, trap and datapath
//               strobe bundle for the multi-cycle control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if #(
    parameter int ALU_OP_W = 3
);
    logic                instrValid;
    logic                instrReady;
    logic [31:0]         instruction;
    logic                memReady;
    logic                trapAck;
    logic                branch;
    logic                memRead;
    logic                memWrite;
    logic                memToReg;
    logic                aluSrc;
    logic                regWrite;
    logic                pcWrite;
    logic [ALU_OP_W-1:0] aluOp;
    logic                illegal;
    logic [1:0]          trapCause;
    logic [2:0]          state;

    modport master (
        output instrValid, instruction, memReady, trapAck,
        input  instrReady, branch, memRead, memWrite, memToReg, aluSrc,
               regWrite, pcWrite, aluOp, illegal, trapCause, state
    );

    modport slave (
        input  instrValid, instruction, memReady, trapAck,
        output instrReady, branch, memRead, memWrite, memToReg, aluSrc,
               regWrite, pcWrite, aluOp, illegal, trapCause, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : RV32 multi-cycle control sequencer (IDLE/DECODE/EXEC/MEM/WB/
//               TRAP) with memory timeout and illegal-instruction trapping.
//               Optional M extension decode enabled by CONTROL_M_EXT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input wire                  clk,
    input wire                  rst_n,
    multicycle_control_if.slave bus
);
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_trap   = 3'd5;

    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;

    localparam logic [8:0] c_mem_timeout = 9'(MEM_TIMEOUT);

    logic [2:0]  r_state;
    logic [31:0] r_ir;
    logic [7:0]  r_wait;
    logic [1:0]  r_cause;

    logic [6:0]  w_opcode;
    logic [6:0]  w_func7;
    logic        w_m_ext;
    logic        w_func7_ok;
    logic        w_op_known;
    logic [2:0]  w_alu_cls;
    logic        w_alu_src;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_branch;
    logic [8:0]  w_wait_next;
    logic        w_unused_ir;

    assign w_opcode    = r_ir[6:0];
    assign w_func7     = r_ir[31:25];
    assign w_is_load   = (w_opcode == c_opc_load);
    assign w_is_store  = (w_opcode == c_opc_store);
    assign w_is_branch = (w_opcode == c_opc_branch);
    assign w_wait_next = {1'b0, r_wait} + 9'd1;
    assign w_unused_ir = ^r_ir[24:7];

`ifdef CONTROL_M_EXT_EN
    assign w_m_ext = (w_func7 == 7'b0000001);
`else
    assign w_m_ext = 1'b0;
`endif

    assign w_func7_ok = (w_func7 == 7'b0000000) || (w_func7 == 7'b0100000) || w_m_ext;

    // ALU class and operand select depend only on the opcode held in IR.
    always_comb begin
        w_op_known = 1'b1;
        w_alu_cls  = 3'b111;
        w_alu_src  = 1'b0;
        case (w_opcode)
            c_opc_load, c_opc_store: begin
                w_alu_cls = 3'b000;
                w_alu_src = 1'b1;
            end
            c_opc_branch: w_alu_cls = 3'b001;
            c_opc_op:     w_alu_cls = w_m_ext ? 3'b101 : 3'b010;
            c_opc_opimm: begin
                w_alu_cls = 3'b110;
                w_alu_src = 1'b1;
            end
            c_opc_jal, c_opc_jalr, c_opc_lui, c_opc_auipc: begin
                w_alu_cls = 3'b011;
                w_alu_src = 1'b1;
            end
            default: w_op_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_ir    <= 32'd0;
            r_wait  <= 8'd0;
            r_cause <= 2'b00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.instrValid) begin
                        r_ir    <= bus.instruction;
                        r_state <= c_st_decode;
                    end
                end
                c_st_decode: begin
                    if (!w_op_known) begin
                        r_cause <= 2'b01;
                        r_state <= c_st_trap;
                    end else if ((w_opcode == c_opc_op) && !w_func7_ok) begin
                        r_cause <= 2'b10;
                        r_state <= c_st_trap;
                    end else begin
                        r_state <= c_st_exec;
                    end
                end
                c_st_exec: begin
                    r_wait <= 8'd0;
                    if (w_is_branch) begin
                        r_state <= c_st_idle;
                    end else if (w_is_load || w_is_store) begin
                        r_state <= c_st_mem;
                    end else begin
                        r_state <= c_st_wb;
                    end
                end
                c_st_mem: begin
                    // Completion takes priority over the timeout in the same cycle.
                    if (bus.memReady) begin
                        r_state <= w_is_load ? c_st_wb : c_st_idle;
                    end else if (w_wait_next == c_mem_timeout) begin
                        r_cause <= 2'b11;
                        r_state <= c_st_trap;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                c_st_wb: r_state <= c_st_idle;
                c_st_trap: begin
                    if (bus.trapAck) begin
                        r_cause <= 2'b00;
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    always_comb begin
        bus.instrReady = 1'b0;
        bus.branch     = 1'b0;
        bus.memRead    = 1'b0;
        bus.memWrite   = 1'b0;
        bus.memToReg   = 1'b0;
        bus.aluSrc     = 1'b0;
        bus.regWrite   = 1'b0;
        bus.pcWrite    = 1'b0;
        bus.aluOp      = ALU_OP_W'(3'b111);
        bus.illegal    = 1'b0;
        case (r_state)
            c_st_idle: bus.instrReady = 1'b1;
            c_st_decode: begin
                bus.aluOp  = ALU_OP_W'(w_alu_cls);
                bus.aluSrc = w_alu_src;
            end
            c_st_exec: begin
                bus.aluOp   = ALU_OP_W'(w_alu_cls);
                bus.aluSrc  = w_alu_src;
                bus.branch  = w_is_branch;
                bus.pcWrite = w_is_branch;
            end
            c_st_mem: begin
                bus.aluOp    = ALU_OP_W'(w_alu_cls);
                bus.aluSrc   = w_alu_src;
                bus.memRead  = w_is_load;
                bus.memWrite = w_is_store;
                bus.pcWrite  = w_is_store & bus.memReady;
            end
            c_st_wb: begin
                bus.regWrite = 1'b1;
                bus.pcWrite  = 1'b1;
                bus.memToReg = w_is_load;
            end
            c_st_trap: bus.illegal = 1'b1;
            default: ;
        endcase
    end

    assign bus.trapCause = r_cause;
    assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed plus randomized bench for multicycle_control with a
//               per-instruction phase model and immediate-assertion checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
    localparam int c_tmo = 4;

`ifdef CONTROL_M_EXT_EN
    localparam bit c_mext = 1'b1;
`else
    localparam bit c_mext = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.ALU_OP_W(3)) bus ();

    multicycle_control #(.ALU_OP_W(3), .MEM_TIMEOUT(c_tmo)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {state, instrReady, branch, memRead, memWrite, memToReg, aluSrc, regWrite, pcWrite, aluOp, illegal, trapCause}
    logic [16:0] w_obs;
    assign w_obs = {bus.state, bus.instrReady, bus.branch, bus.memRead, bus.memWrite,
                    bus.memToReg, bus.aluSrc, bus.regWrite, bus.pcWrite, bus.aluOp,
                    bus.illegal, bus.trapCause};

    function automatic logic [16:0] mk(input logic [2:0] st, input logic rdy, input logic br,
                                       input logic mr, input logic mw, input logic m2r,
                                       input logic src, input logic rw, input logic pc,
                                       input logic [2:0] op, input logic ill,
                                       input logic [1:0] cause);
        return {st, rdy, br, mr, mw, m2r, src, rw, pc, op, ill, cause};
    endfunction

    function automatic bit is_legal_opc(input logic [6:0] o);
        return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b1100011) ||
               (o == 7'b0110011) || (o == 7'b0010011) || (o == 7'b1101111) ||
               (o == 7'b1100111) || (o == 7'b0110111) || (o == 7'b0010111);
    endfunction

    function automatic logic [2:0] ref_alu(input logic [31:0] ins);
        logic [6:0] o;
        o = ins[6:0];
        if (o == 7'b0000011 || o == 7'b0100011) return 3'b000;
        if (o == 7'b1100011) return 3'b001;
        if (o == 7'b0110011) return (c_mext && ins[31:25] == 7'b0000001) ? 3'b101 : 3'b010;
        if (o == 7'b0010011) return 3'b110;
        if (is_legal_opc(o)) return 3'b011;
        return 3'b111;
    endfunction

    function automatic logic ref_src(input logic [31:0] ins);
        return is_legal_opc(ins[6:0]) && (ins[6:0] != 7'b0110011) && (ins[6:0] != 7'b1100011);
    endfunction

    function automatic logic [1:0] ref_cause(input logic [31:0] ins);
        logic [6:0] f7;
        f7 = ins[31:25];
        if (!is_legal_opc(ins[6:0])) return 2'b01;
        if (ins[6:0] == 7'b0110011 &&
            !(f7 == 7'b0000000 || f7 == 7'b0100000 || (c_mext && f7 == 7'b0000001)))
            return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [16:0] exp);
        checks++;
        assert (w_obs === exp)
        else begin
            errors++;
            $error("FAIL %s step=%0d observed=%b expected=%b", tag, step, w_obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        bus.instrValid  = 1'($urandom_range(0, 1));
        bus.instruction = $urandom;
        bus.memReady    = 1'($urandom_range(0, 1));
        bus.trapAck     = 1'($urandom_range(0, 1));
    endtask

    localparam logic [16:0] c_idle = 17'b000_1_0000000_111_0_00;

    // Walks one instruction from its accept cycle through to the edge that returns to IDLE.
    // lo = MEM cycles with memReady low before completion; tcyc = TRAP cycles before trapAck.
    task automatic run_instr(input logic [31:0] ins, input int lo, input int tcyc);
        logic [6:0] opc;
        logic [2:0] op;
        logic       src;
        logic [1:0] cause;
        bit         ld, st, need_wb, done;
        int         k;
        opc     = ins[6:0];
        op      = ref_alu(ins);
        src     = ref_src(ins);
        cause   = ref_cause(ins);
        ld      = (opc == 7'b0000011);
        st      = (opc == 7'b0100011);
        need_wb = 1'b0;
        step++;
        bus.instrValid  = 1'b1;
        bus.instruction = ins;
        bus.memReady    = 1'($urandom_range(0, 1));
        bus.trapAck     = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle_accept", c_idle);
        next_cycle();
        junk();
        @(negedge clk);
        check("decode", mk(3'd1, 0, 0, 0, 0, 0, src, 0, 0, op, 0, 2'b00));
        next_cycle();
        if (cause == 2'b00) begin
            junk();
            @(negedge clk);
            if (opc == 7'b1100011)
                check("exec_branch", mk(3'd2, 0, 1, 0, 0, 0, src, 0, 1, op, 0, 2'b00));
            else
                check("exec", mk(3'd2, 0, 0, 0, 0, 0, src, 0, 0, op, 0, 2'b00));
            next_cycle();
            if (ld || st) begin
                k    = 0;
                done = 1'b0;
                while (!done) begin
                    k++;
                    junk();
                    bus.memReady = (k > lo);
                    @(negedge clk);
                    check("mem", mk(3'd3, 0, 0, ld, st, 0, src, 0, st && (k > lo), op, 0, 2'b00));
                    if (k > lo) begin
                        done    = 1'b1;
                        need_wb = ld;
                    end else if (k == c_tmo) begin
                        done  = 1'b1;
                        cause = 2'b11;
                    end
                    next_cycle();
                end
            end else if (opc != 7'b1100011) begin
                need_wb = 1'b1;
            end
            if (need_wb) begin
                junk();
                @(negedge clk);
                check("wb", mk(3'd4, 0, 0, 0, 0, ld, 0, 1, 1, 3'b111, 0, 2'b00));
                next_cycle();
            end
        end
        if (cause != 2'b00) begin
            for (int t = 1; t <= tcyc; t++) begin
                junk();
                bus.trapAck = (t == tcyc);
                @(negedge clk);
                check("trap", mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, cause));
                next_cycle();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        logic [6:0]  opc_tab [9];
        logic [6:0]  bad_tab [5];
        logic [6:0]  f7_tab  [4];
        opc_tab = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0010011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        bad_tab = '{7'b0101111, 7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011};
        f7_tab  = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b1010101};

        // Reset with a pending request must stay in IDLE.
        rst_n           = 1'b0;
        bus.instrValid  = 1'b1;
        bus.instruction = 32'h00500093;
        bus.memReady    = 1'b0;
        bus.trapAck     = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset", c_idle);
        next_cycle();
        rst_n = 1'b1;

        run_instr(32'h00500093, 0, 1);   // OP-IMM
        run_instr(32'h00002103, 3, 1);   // LOAD, ready in 4th MEM cycle
        run_instr(32'h00112023, 2, 1);   // STORE
        run_instr(32'h00208463, 0, 1);   // BRANCH
        run_instr(32'h0000202F, 0, 3);   // AMO -> illegal opcode
        run_instr(32'h02208033, 0, 2);   // OP func7=0000001
        run_instr(32'h40208033, 0, 1);   // OP func7=0100000 (SUB)
        run_instr(32'h00002103, 99, 2);  // LOAD timeout
        run_instr(32'h00112023, 99, 1);  // STORE timeout

        // Reset while waiting in MEM.
        step++;
        bus.instrValid  = 1'b1;
        bus.instruction = 32'h00002103;
        @(negedge clk);
        check("rst_mem_idle", c_idle);
        next_cycle();
        junk();
        next_cycle();
        junk();
        next_cycle();
        junk();
        bus.memReady = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        check("rst_mem_pre", mk(3'd3, 0, 0, 1, 0, 0, 1, 0, 0, 3'b000, 0, 2'b00));
        next_cycle();
        rst_n = 1'b1;
        bus.instrValid = 1'b0;
        @(negedge clk);
        check("rst_mem_post", c_idle);
        next_cycle();

        // Reset while in TRAP clears the cause.
        step++;
        bus.instrValid  = 1'b1;
        bus.instruction = 32'h0000007F;
        next_cycle();
        bus.instrValid = 1'b0;
        next_cycle();
        bus.trapAck = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        check("rst_trap_pre", mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 2'b01));
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_trap_post", c_idle);
        next_cycle();

        // Randomized instruction mix.
        for (int n = 0; n < 60; n++) begin
            int sel;
            sel = int'($urandom_range(0, 10));
            ins = $urandom;
            if (sel < 9) ins[6:0] = opc_tab[sel];
            else         ins[6:0] = bad_tab[$urandom_range(0, 4)];
            if (ins[6:0] == 7'b0110011) ins[31:25] = f7_tab[$urandom_range(0, 3)];
            run_instr(ins, int'($urandom_range(0, 5)), int'($urandom_range(1, 3)));
        end

        bus.instrValid = 1'b0;
        @(negedge clk);
        check("final_idle", c_idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
